// File: rtl/ps_flops_alu_issue_ret_if.sv
// ALU-to-issue completion return bus: push side from the ALU, pop side toward issue.
interface ps_flops_alu_issue_ret_if #(
    parameter int unsigned CNT_W = 3
);
    logic             in_alu_done;
    logic [5:0]       in_wfid;
    logic [31:0]      in_instr_pc;
    logic [11:0]      in_dest1_addr;
    logic [11:0]      in_dest2_addr;
    logic             in_flush;
    logic             in_issue_ack;
    logic             out_alu_ready;
    logic             out_valid;
    logic [5:0]       out_wfid;
    logic [31:0]      out_instr_pc;
    logic [11:0]      out_dest1_addr;
    logic [11:0]      out_dest2_addr;
    logic [CNT_W-1:0] out_count;
    logic             out_overflow;
    logic             out_underflow;

    // Environment side: drives pushes, pops and flush.
    modport master (
        output in_alu_done, in_wfid, in_instr_pc, in_dest1_addr, in_dest2_addr,
               in_flush, in_issue_ack,
        input  out_alu_ready, out_valid, out_wfid, out_instr_pc, out_dest1_addr,
               out_dest2_addr, out_count, out_overflow, out_underflow
    );

    // Buffer side.
    modport slave (
        input  in_alu_done, in_wfid, in_instr_pc, in_dest1_addr, in_dest2_addr,
               in_flush, in_issue_ack,
        output out_alu_ready, out_valid, out_wfid, out_instr_pc, out_dest1_addr,
               out_dest2_addr, out_count, out_overflow, out_underflow
    );
endinterface

// File: rtl/ps_flops_alu_issue_ret.sv
// In-order completion buffer on the ALU-to-issue return path, with ALU back-pressure
// and sticky overflow/underflow protocol flags.
module ps_flops_alu_issue_ret #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    ps_flops_alu_issue_ret_if.slave      bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [5:0]  wfid;
        logic [31:0] pc;
        logic [11:0] dest1;
        logic [11:0] dest2;
    } rec_t;

    rec_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             full_c;
    logic             empty_c;
    logic             push_c;
    logic             pop_c;
    rec_t             rec_in_c;
    rec_t             head_c;

    // Ready depends on registered occupancy only, so a push while full is dropped
    // even when issue pops in the same cycle.
    always_comb begin
        full_c   = (count_q == CNT_W'(DEPTH));
        empty_c  = (count_q == '0);
        push_c   = bus.in_alu_done  & ~full_c  & ~bus.in_flush;
        pop_c    = bus.in_issue_ack & ~empty_c & ~bus.in_flush;
        rec_in_c = '{wfid:  bus.in_wfid,
                     pc:    bus.in_instr_pc,
                     dest1: bus.in_dest1_addr,
                     dest2: bus.in_dest2_addr};
    end

    // Next-state: flush wins over push/pop and leaves the sticky flags alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (bus.in_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
            ovf_d   = ovf_q | (bus.in_alu_done  & full_c);
            unf_d   = unf_q | (bus.in_issue_ack & empty_c);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is cleared on reset so idle outputs are deterministic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_c) begin
            mem_q[wr_ptr_q] <= rec_in_c;
        end
    end

    always_comb begin
        head_c             = mem_q[rd_ptr_q];
        bus.out_alu_ready  = ~full_c;
        bus.out_valid      = ~empty_c;
        bus.out_wfid       = head_c.wfid;
        bus.out_instr_pc   = head_c.pc;
        bus.out_dest1_addr = head_c.dest1;
        bus.out_dest2_addr = head_c.dest2;
        bus.out_count      = count_q;
        bus.out_overflow   = ovf_q;
        bus.out_underflow  = unf_q;
    end
endmodule

// File: doc/ps_flops_alu_issue_ret.md
Name: ps_flops_alu_issue_ret

Overview:
Return-path pipeline buffer from the ALU back to issue. It carries ALU completion records (wavefront id, PC, destination addresses) that issue uses to clear scoreboard entries and release wavefronts. The issue-to-ALU stage needs no flow control, but this path does: issue may stall the acknowledgement, so the block holds up to DEPTH completions in order. It also back-pressures the ALU and flags protocol violations.

Parameters:
DEPTH, 4, number of buffered completion records; power of 2, at least 2.
CNT_W, 3, width of occupancy count; must equal log2(DEPTH)+1.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (asserted at 0); clears all state immediately
in_alu_done  input  1  ALU presents a completion record this cycle (push request)
in_wfid  input  6  wavefront id of completing instruction
in_instr_pc  input  32  PC of completing instruction
in_dest1_addr  input  12  first destination register address
in_dest2_addr  input  12  second destination register address
in_flush  input  1  synchronous flush of all buffered records
out_alu_ready  output  1  buffer can accept a push this cycle
out_valid  output  1  head record is valid
out_wfid  output  6  head record wavefront id
out_instr_pc  output  32  head record PC
out_dest1_addr  output  12  head record dest1
out_dest2_addr  output  12  head record dest2
in_issue_ack  input  1  issue consumes the head record this cycle (pop)
out_count  output  CNT_W  current occupancy, 0..DEPTH
out_overflow  output  1  sticky: push attempted while full
out_underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Storage: circular buffer of DEPTH entries, each 62 bits (6+32+12+12). Uses write pointer, read pointer and occupancy counter; pointers wrap modulo DEPTH.
- Reset (rst=0, asynchronous): pointers=0, count=0, all storage entries=0, sticky flags=0. Resulting outputs: out_valid=0, out_alu_ready=1, out_count=0, all data outputs 0, out_overflow=0, out_underflow=0. Reset mid-operation discards all records with no partial state.
- out_alu_ready = (count != DEPTH). This is combinational from registered count only and does not depend on in_issue_ack.
- out_valid = (count != 0). Data outputs are a combinational read of the entry at the read pointer. While out_valid=0, the data outputs show the last-popped or reset content; that content is don't-care but must be deterministic.
- Push occurs when in_alu_done=1 and count<DEPTH. The record is written at the write pointer, and the write pointer increments.
- Pop occurs when in_issue_ack=1 and count>0. The read pointer increments.
- Latency: a record pushed in cycle N is visible at the outputs with out_valid=1 in cycle N+1 at the earliest. There is no same-cycle bypass.
- Simultaneous push and pop with 0<count<DEPTH: both take effect and count is unchanged.
- Push while full: the record is dropped, even if a pop happens the same cycle, because ready is not ack-dependent. out_overflow is set to 1 and count follows the pop only.
- Pop while empty: ignored; out_underflow is set to 1.
- Ordering: strict FIFO; records exit in push order.
- Flush (in_flush=1): next cycle pointers=0 and count=0. Flush overrides a same-cycle push and pop; the push is discarded and does NOT set overflow. Storage contents are not cleared and sticky flags are retained.
- Sticky flags clear only on reset.
- out_count is registered occupancy, updated the cycle after a push or pop.

Test Plan:
- Reset and idle: hold rst=0, then release. Required: out_valid=0, out_alu_ready=1, out_count=0, all data outputs 0, both flags 0. Then assert rst=0 asynchronously mid-cycle while count=2; count must go to 0 without waiting for a clock edge.
- Single push/pop: push wfid=6'h05, pc=32'h0000_0100, dest1=12'h010, dest2=12'h208. Next cycle: out_valid=1 with the same data and out_count=1. Assert ack for one cycle; the following cycle out_valid=0 and count=0.
- Fill and order: with ack=0, push wfids 1,2,3,4. Then out_alu_ready=0 and count=4. A 5th push of wfid=9 sets out_overflow=1 and is dropped. Pop 4 times; wfids exit in order 1,2,3,4.
- Simultaneous push/pop at count=2: push wfid=7 with ack=1 for 3 cycles. count stays 2 and head order is preserved. Repeat across pointer wrap (more than DEPTH total pushes) with correct data.
- Underflow and flush: ack while empty sets out_underflow=1 and count stays 0. With count=3, assert in_flush together with in_alu_done=1 and ack=1. Next cycle count=0, out_valid=0, and out_overflow is unchanged.
- Full with ack: count=4, in_alu_done=1 and in_issue_ack=1 in the same cycle. The push is dropped, overflow=1, count=3, and the head advances.
